// File: rtl/bp_cce_mem_cmd_arbiter.sv
// Round-robin arbiter sharing one mem_cmd port between CCE engines, one-entry registered output stage.
// Optional outstanding-command credit counter built when BP_CCE_MEM_ARB_CREDIT_EN is defined.
module bp_cce_mem_cmd_arbiter #(
   parameter int num_req_p   = 2,
   parameter int msg_width_p = 128,
   parameter int credits_p   = 4,
   localparam int lg_num_req_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1,
   localparam int lg_credits_lp = (credits_p + 1 > 1) ? $clog2(credits_p + 1) : 1
) (
   input  logic                             clk_i,
   input  logic                             reset_n_i,
   input  logic [num_req_p*msg_width_p-1:0] req_msg_i,
   input  logic [num_req_p-1:0]             req_v_i,
   output logic [num_req_p-1:0]             req_yumi_o,
   output logic [msg_width_p-1:0]           mem_cmd_o,
   output logic                             mem_cmd_v_o,
   input  logic                             mem_cmd_ready_i,
   input  logic                             credit_return_i,
   output logic [lg_num_req_lp-1:0]         grant_id_o,
   output logic                             credits_empty_o,
   output logic                             credits_full_o
);

   localparam logic [lg_num_req_lp-1:0] last_rst_lp = lg_num_req_lp'(num_req_p - 1);

   logic                     out_v_q;
   logic [msg_width_p-1:0]   out_msg_q;
   logic [lg_num_req_lp-1:0] out_id_q;
   logic [lg_num_req_lp-1:0] last_q;
   logic [lg_num_req_lp-1:0] winner;
   logic                     drain;
   logic                     open;
   logic                     credit_ok;
   logic                     grant;

   // Scan from the farthest index to the nearest so the entry right after last_q wins.
   function automatic logic [lg_num_req_lp-1:0] rr_pick(
      input logic [lg_num_req_lp-1:0] last,
      input logic [num_req_p-1:0]     v
   );
      int idx;
      rr_pick = last;
      for (int i = num_req_p; i >= 1; i--) begin
         idx = (int'(last) + i) % num_req_p;
         if (v[idx]) rr_pick = idx[lg_num_req_lp-1:0];
      end
   endfunction

   assign winner = rr_pick(last_q, req_v_i);
   assign drain  = out_v_q & mem_cmd_ready_i;
   assign open   = ~out_v_q | drain;
   assign grant  = reset_n_i & open & (|req_v_i) & credit_ok;

   always_comb begin
      req_yumi_o = '0;
      if (grant) req_yumi_o[winner] = 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         out_v_q   <= 1'b0;
         out_msg_q <= '0;
         out_id_q  <= '0;
         last_q    <= last_rst_lp;
      end else if (grant) begin
         out_v_q   <= 1'b1;
         out_msg_q <= req_msg_i[winner*msg_width_p +: msg_width_p];
         out_id_q  <= winner;
         last_q    <= winner;
      end else if (drain) begin
         out_v_q   <= 1'b0;
      end
   end

   assign mem_cmd_v_o = out_v_q;
   assign mem_cmd_o   = out_msg_q;
   assign grant_id_o  = out_id_q;

`ifdef BP_CCE_MEM_ARB_CREDIT_EN
   localparam logic [lg_credits_lp-1:0] credits_max_lp = lg_credits_lp'(credits_p);

   logic [lg_credits_lp-1:0] count_q;

   // Registered count only, so a return never opens a grant in its own cycle.
   assign credit_ok = (count_q != '0);

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         count_q <= credits_max_lp;
      end else begin
         if (grant && !credit_return_i)
            count_q <= count_q - 1'b1;
         else if (credit_return_i && !grant && (count_q != credits_max_lp))
            count_q <= count_q + 1'b1;
         if (credit_return_i && !grant)
            assert (count_q != credits_max_lp)
            else $error("credit returned while counter already full");
      end
   end

   assign credits_empty_o = (count_q == '0);
   assign credits_full_o  = (count_q == credits_max_lp);
`else
   logic unused;
   assign unused          = credit_return_i | (credits_p < 1) | (lg_credits_lp < 1);
   assign credit_ok       = 1'b1;
   assign credits_empty_o = 1'b0;
   assign credits_full_o  = 1'b1;
`endif

endmodule

// File: doc/bp_cce_mem_cmd_arbiter.md
# bp_cce_mem_cmd_arbiter

Round-robin arbiter and flow-control scheduler for the CCE outbound memory command channel. It shares the single `mem_cmd` port between several CCE message engines, such as the cached-coherence engine, the uncached engine and a writeback engine. Each engine presents a complete memory command message; the arbiter grants one per cycle, registers it in a one-entry output stage and presents it to the memory-side FIFO with ready&valid handshaking. An optional credit counter bounds the number of outstanding memory commands.

## Interface
Parameters:
- `num_req_p`, default 2: number of requesting engines (≥1).
- `msg_width_p`, default 128: width of one memory command message (`cce_mem_msg_width_lp` at instantiation).
- `credits_p`, default 4: maximum outstanding commands when credits are compiled in (≥1).
- `lg_num_req_lp`: localparam, `BSG_SAFE_CLOG2(num_req_p)`.
- `lg_credits_lp`: localparam, `BSG_SAFE_CLOG2(credits_p+1)`.

Ports:
- `clk_i`  in  1  the single clock.
- `reset_n_i`  in  1  reset, synchronous, active-low.
- `req_msg_i`  in  num_req_p×msg_width_p  per-requester command message.
- `req_v_i`  in  num_req_p  per-requester valid.
- `req_yumi_o`  out  num_req_p  one-hot consume strobe (valid->yumi); at most one bit set.
- `mem_cmd_o`  out  msg_width_p  registered command.
- `mem_cmd_v_o`  out  1  output valid.
- `mem_cmd_ready_i`  in  1  downstream ready.
- `credit_return_i`  in  1  one memory response consumed; returns one credit.
- `grant_id_o`  out  lg_num_req_lp  source index of the message held in the output stage.
- `credits_empty_o`  out  1  credit count == 0.
- `credits_full_o`  out  1  credit count == credits_p.

## Operation
- **Output stage:** one register holding `{valid, msg, id}`.
  - `drain = mem_cmd_v_o & mem_cmd_ready_i`.
  - `open = ~mem_cmd_v_o | drain`.
- **Grant condition:** `grant = open & (|req_v_i) & credit_ok`.
  - `credit_ok` is `count != 0`, using the registered count only; a `credit_return_i` in the same cycle does not enable a grant.
  - Without credits, `credit_ok = 1`.
- **Round-robin pick:** `last_q` holds the index of the last grant. The winner is the first asserted `req_v_i` at index `last_q+1, last_q+2, …`, wrapping modulo `num_req_p`; `last_q` itself is checked last.
  - `last_q` updates only on grant.
  - With `num_req_p = 1` the pick is always 0.
- **Grant cycle:** `req_yumi_o[winner]=1` combinationally in the same cycle. On the next edge the output stage loads `req_msg_i[winner]` and `winner` and sets valid.
- **Drain without grant:** valid clears on the next edge.
- **Hold:** while `mem_cmd_v_o & ~mem_cmd_ready_i`, `mem_cmd_o` and `grant_id_o` are held stable and no yumi is issued.
- **Credit count update:**
  - grant & ~return: −1.
  - return & ~grant: +1.
  - both, or neither: unchanged.
- **Credit overflow:** a return at `count == credits_p` is a protocol error. The count saturates, and a simulation assertion (`$error`) fires.
- **Requester contract:** requesters must not drop `req_v_i` or change `req_msg_i` while valid and not yumi'd. The arbiter does not check this.

## Timing
- **Reset values** (edge with `reset_n_i=0`):
  - `mem_cmd_v_o=0`, `mem_cmd_o=0`, `grant_id_o=0`.
  - `last_q=num_req_p-1`, so requester 0 wins first.
  - `count=credits_p`, so `credits_full_o=1` and `credits_empty_o=0`.
  - `req_yumi_o=0` while reset is low.
- **Reset mid-operation:** discards a held output message without `drain`; the engine has already been yumi'd. Any credits in flight are forgotten.
- **Latency:** 1 cycle from `req_v_i`/`req_yumi_o` to `mem_cmd_v_o`.
- **Throughput:** 1 message per cycle when `mem_cmd_ready_i` is held high and credits are available. A drain and a new grant may occur in the same cycle.
- **Path constraints:**
  - `req_yumi_o` depends combinationally on `req_v_i`, `mem_cmd_ready_i` and registered state only. It must not depend on `req_msg_i`.
  - No combinational path from `credit_return_i` to any output.

## Configuration
- **`BP_CCE_MEM_ARB_CREDIT_EN` defined:** the credit counter, `credit_ok` gating and the overflow assertion are built as above.
- **Undefined:** no counter is built and `credit_ok=1`. `credits_empty_o` is tied 0 and `credits_full_o` is tied 1. `credit_return_i` is ignored. The `credits_p` parameter is unused.

## Test plan
- **Single requester:** reset, then `req_v_i=2'b01`, ready=1 → `req_yumi_o=2'b01` that cycle; next cycle `mem_cmd_v_o=1`, `mem_cmd_o=req_msg_i[0]`, `grant_id_o=0`.
- **Fairness:** both requesters valid continuously, ready=1, `credit_return_i=1` every cycle → grants alternate 0,1,0,1 with no bubble; count stays at 4 after the first return.
- **Credit exhaustion** (CREDIT_EN, `credits_p=4`): both valid, no returns → exactly 4 grants, then `credits_empty_o=1` and yumi=0. One `credit_return_i` pulse → exactly one further grant, in the cycle after the pulse.
- **Backpressure:** output valid, ready=0 for 5 cycles → `mem_cmd_o` and `grant_id_o` stable, `req_yumi_o=0`. Ready=1 → drain and a new grant in the same cycle.
- **Simultaneous grant and return:** at `count=1` → count remains 1. Return at `count=4` → count stays 4 and the assertion fires.
- **Reset mid-operation:** output valid with `count=1`, drive `reset_n_i=0` for one edge → `mem_cmd_v_o=0` and `count=4`; with both requesters then valid, requester 0 is granted first.
